// File: rtl/user_proj_counter_pkg.sv
// Shared constants and helpers for the counter-array user project.
package user_proj_counter_pkg;

    // Register kind within a channel's four-word block
    localparam logic [1:0] REG_CTRL    = 2'd0;
    localparam logic [1:0] REG_VALUE   = 2'd1;
    localparam logic [1:0] REG_COMPARE = 2'd2;
    localparam logic [1:0] REG_STATUS  = 2'd3;

    // Word index of the read-only interrupt summary
    localparam logic [5:0] WORD_IRQSUM = 6'd32;

    // CTRL bit positions
    localparam int CTRL_EN     = 0;
    localparam int CTRL_RELOAD = 1;
    localparam int CTRL_DOWN   = 2;
    localparam int CTRL_IRQ_EN = 3;
    localparam int CTRL_W      = 4;

    // Logic-analyser control bits
    localparam int LA_CLEAR_BIT  = 64;
    localparam int LA_FREEZE_BIT = 65;

    // Replace the bytes of old_v selected by sel with the bytes of new_v
    function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  sel);
        logic [31:0] res;
        for (int b = 0; b < 4; b++) begin
            res[8*b +: 8] = sel[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/user_proj_counter_array_channel.sv
// One up/down counter channel: CTRL, VALUE, COMPARE and sticky MATCH.
module counter_channel
    import user_proj_counter_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_ctrl,
    input  logic        wr_value,
    input  logic        wr_compare,
    input  logic        wr_status,
    input  logic [3:0]  sel,
    input  logic [31:0] wdata,
    input  logic        clear,
    input  logic        freeze,
    output logic [31:0] ctrl_rd,
    output logic [31:0] value_rd,
    output logic [31:0] compare_rd,
    output logic [31:0] status_rd,
    output logic        match,
    output logic        irq_req
);

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CTRL_W-1:0] ctrl_r;
    logic [CNT_W-1:0]  value_r;
    logic [CNT_W-1:0]  compare_r;
    logic              match_r;

    logic [CTRL_W-1:0] ctrl_next_s;
    logic [CNT_W-1:0]  value_next_s;
    logic [CNT_W-1:0]  compare_next_s;
    logic              match_next_s;
    logic [CNT_W-1:0]  count_next_s;
    logic              at_end_s;
    logic              count_en_s;
    logic              match_evt_s;
    logic [31:0]       value_merged_s;
    logic [31:0]       compare_merged_s;

    // Next-state logic: counting step, then LA clear > bus write > count on VALUE
    always_comb begin
        count_en_s       = ctrl_r[CTRL_EN] & ~freeze;
        at_end_s         = 1'b0;
        count_next_s     = value_r;
        value_merged_s   = byte_merge(32'(value_r), wdata, sel);
        compare_merged_s = byte_merge(32'(compare_r), wdata, sel);

        if (ctrl_r[CTRL_DOWN]) begin
            at_end_s = (value_r == {CNT_W{1'b0}});
            if (at_end_s) begin
                count_next_s = ctrl_r[CTRL_RELOAD] ? compare_r : {CNT_W{1'b1}};
            end else begin
                count_next_s = value_r - ONE;
            end
        end else begin
            at_end_s = (value_r == compare_r);
            if (at_end_s && ctrl_r[CTRL_RELOAD]) begin
                count_next_s = {CNT_W{1'b0}};
            end else begin
                count_next_s = value_r + ONE;
            end
        end

        match_evt_s = count_en_s & at_end_s;

        if (clear) begin
            value_next_s = {CNT_W{1'b0}};
        end else if (wr_value) begin
            value_next_s = value_merged_s[CNT_W-1:0];
        end else if (count_en_s) begin
            value_next_s = count_next_s;
        end else begin
            value_next_s = value_r;
        end

        // A fresh match wins over a simultaneous write-1-to-clear
        if (match_evt_s) begin
            match_next_s = 1'b1;
        end else if (wr_status && sel[0] && wdata[0]) begin
            match_next_s = 1'b0;
        end else begin
            match_next_s = match_r;
        end

        if (wr_ctrl && sel[0]) begin
            ctrl_next_s = wdata[CTRL_W-1:0];
        end else begin
            ctrl_next_s = ctrl_r;
        end

        if (wr_compare) begin
            compare_next_s = compare_merged_s[CNT_W-1:0];
        end else begin
            compare_next_s = compare_r;
        end
    end

    // Channel state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_r    <= {CTRL_W{1'b0}};
            value_r   <= {CNT_W{1'b0}};
            compare_r <= {CNT_W{1'b0}};
            match_r   <= 1'b0;
        end else begin
            ctrl_r    <= ctrl_next_s;
            value_r   <= value_next_s;
            compare_r <= compare_next_s;
            match_r   <= match_next_s;
        end
    end

    assign ctrl_rd    = {{(32-CTRL_W){1'b0}}, ctrl_r};
    assign value_rd   = 32'(value_r);
    assign compare_rd = 32'(compare_r);
    assign status_rd  = {31'd0, match_r};
    assign match      = match_r;
    assign irq_req    = match_r & ctrl_r[CTRL_IRQ_EN];

endmodule

// File: rtl/user_proj_counter_array.sv
// Counter-array user project: Wishbone register file, LA/IO/IRQ mapping.
module user_proj_counter_array
    import user_proj_counter_pkg::*;
#(
    parameter int          NUM_CH   = 4,
    parameter int          CNT_W    = 32,
    parameter logic [31:0] BASE_ADR = 32'h3000_0000,
    parameter int          IO_LSB   = 8
) (
`ifdef USE_POWER_PINS
    inout  wire          vccd1,
    inout  wire          vssd1,
`endif
    input  logic         wb_clk_i,
    input  logic         wb_rst_i,
    input  logic         wbs_cyc_i,
    input  logic         wbs_stb_i,
    input  logic         wbs_we_i,
    input  logic [3:0]   wbs_sel_i,
    input  logic [31:0]  wbs_adr_i,
    input  logic [31:0]  wbs_dat_i,
    output logic         wbs_ack_o,
    output logic [31:0]  wbs_dat_o,
    input  logic [127:0] la_data_in,
    input  logic [127:0] la_oenb,
    output logic [127:0] la_data_out,
    input  logic [37:0]  io_in,
    output logic [37:0]  io_out,
    output logic [37:0]  io_oeb,
    output logic [2:0]   irq
);

    logic                 ack_r;
    logic [31:0]          dat_r;
    logic                 irq0_r;

    logic                 hit_s;
    logic                 wr_s;
    logic [5:0]           word_s;
    logic [2:0]           ch_s;
    logic [1:0]           kind_s;
    logic                 la_clear_s;
    logic                 la_freeze_s;
    logic [31:0]          rd_s;
    logic [7:0][3:0][31:0] ch_rd_s;
    logic [7:0]           match_vec_s;
    logic [7:0]           irq_req_vec_s;
    logic                 unused_s;

    assign hit_s       = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:8] == BASE_ADR[31:8]);
    assign word_s      = wbs_adr_i[7:2];
    assign ch_s        = word_s[4:2];
    assign kind_s      = word_s[1:0];
    assign wr_s        = ack_r & wbs_we_i & hit_s;
    assign la_clear_s  = ~la_oenb[LA_CLEAR_BIT] & la_data_in[LA_CLEAR_BIT];
    assign la_freeze_s = ~la_oenb[LA_FREEZE_BIT] & ~la_data_in[LA_FREEZE_BIT];
    assign unused_s    = ^{io_in, la_data_in, la_oenb, wbs_adr_i[1:0]};

    genvar n;
    generate
        for (n = 0; n < 8; n++) begin : g_ch
            if (n < NUM_CH) begin : g_live
                logic wr_ch_s;
                assign wr_ch_s = wr_s & ~word_s[5] & (ch_s == 3'(n));
                counter_channel #(.CNT_W(CNT_W)) u_ch (
                    .clk        (wb_clk_i),
                    .rst        (wb_rst_i),
                    .wr_ctrl    (wr_ch_s & (kind_s == REG_CTRL)),
                    .wr_value   (wr_ch_s & (kind_s == REG_VALUE)),
                    .wr_compare (wr_ch_s & (kind_s == REG_COMPARE)),
                    .wr_status  (wr_ch_s & (kind_s == REG_STATUS)),
                    .sel        (wbs_sel_i),
                    .wdata      (wbs_dat_i),
                    .clear      (la_clear_s),
                    .freeze     (la_freeze_s),
                    .ctrl_rd    (ch_rd_s[n][0]),
                    .value_rd   (ch_rd_s[n][1]),
                    .compare_rd (ch_rd_s[n][2]),
                    .status_rd  (ch_rd_s[n][3]),
                    .match      (match_vec_s[n]),
                    .irq_req    (irq_req_vec_s[n])
                );
            end else begin : g_absent
                assign ch_rd_s[n]       = {4{32'd0}};
                assign match_vec_s[n]   = 1'b0;
                assign irq_req_vec_s[n] = 1'b0;
            end
        end
    endgenerate

    // Read mux: channel blocks, interrupt summary, zero elsewhere
    always_comb begin
        rd_s = 32'd0;
        if (!word_s[5]) begin
            rd_s = ch_rd_s[ch_s][kind_s];
        end else if (word_s == WORD_IRQSUM) begin
            rd_s = {24'd0, irq_req_vec_s};
        end else begin
            rd_s = 32'd0;
        end
    end

    // Single-cycle ack, data valid only alongside ack, registered interrupt
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            ack_r  <= 1'b0;
            dat_r  <= 32'd0;
            irq0_r <= 1'b0;
        end else begin
            ack_r  <= hit_s & ~ack_r;
            dat_r  <= (hit_s && !ack_r) ? rd_s : 32'd0;
            irq0_r <= |irq_req_vec_s;
        end
    end

    // LA and pad mapping of channel 0 VALUE and per-channel MATCH
    always_comb begin
        la_data_out                = {128{1'b0}};
        la_data_out[31:0]          = ch_rd_s[0][1];
        la_data_out[32 +: 8]       = match_vec_s;
        io_out                     = {38{1'b0}};
        io_out[IO_LSB +: NUM_CH]   = match_vec_s[NUM_CH-1:0];
        io_oeb                     = {38{1'b1}};
        io_oeb[IO_LSB +: NUM_CH]   = {NUM_CH{1'b0}};
    end

    assign wbs_ack_o = ack_r;
    assign wbs_dat_o = dat_r;
    assign irq       = {2'b00, irq0_r};

endmodule

// File: tb/tb_user_proj_counter_array.sv
// Scoreboard bench for user_proj_counter_array: reads queue their expected
// data, a negedge monitor pops and compares on every read ack.
module tb_user_proj_counter_array;

    localparam int          NUM_CH = 4;
    localparam int          IO_LSB = 8;
    localparam logic [31:0] BASE   = 32'h3000_0000;

    logic         wb_clk_i = 1'b0;
    logic         wb_rst_i;
    logic         wbs_cyc_i, wbs_stb_i, wbs_we_i;
    logic [3:0]   wbs_sel_i;
    logic [31:0]  wbs_adr_i, wbs_dat_i;
    logic         wbs_ack_o;
    logic [31:0]  wbs_dat_o;
    logic [127:0] la_data_in, la_oenb, la_data_out;
    logic [37:0]  io_in, io_out, io_oeb;
    logic [2:0]   irq;

    int           pass_cnt  = 0;
    int           total_cnt = 0;
    logic [31:0]  exp_q[$];
    string        name_q[$];
    logic         ack_prev = 1'b0;
    string        mon_name;
    logic [31:0]  mon_exp;
    logic [37:0]  exp_oeb;
    int           miss_acks;

    user_proj_counter_array dut (
        .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
        .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i),
        .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
        .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
        .la_data_in(la_data_in), .la_oenb(la_oenb), .la_data_out(la_data_out),
        .io_in(io_in), .io_out(io_out), .io_oeb(io_oeb), .irq(irq)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: actual %0h required %0h", name, act, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge wb_clk_i);
        #1;
    endtask

    function automatic logic [31:0] wa(input int w);
        return BASE + 32'(w * 4);
    endfunction

    // mode 0: plain; 1: LA clear during ack cycle; 2: reset during ack cycle
    task automatic wb_xfer(input logic we, input int w, input logic [31:0] dat,
                           input logic [3:0] sel, input logic [31:0] exp,
                           input string name, input int mode);
        int waited;
        if (!we) begin
            exp_q.push_back(exp);
            name_q.push_back(name);
        end
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
        wbs_adr_i = wa(w); wbs_dat_i = dat; wbs_sel_i = sel;
        tick(1);
        waited = 1;
        while (!wbs_ack_o && waited < 8) begin
            tick(1);
            waited++;
        end
        chk({"ack_latency_", name}, 64'(waited), 64'd1);
        if (mode == 1) la_data_in[64] = 1'b1;
        if (mode == 2) begin
            wb_rst_i = 1'b1;
            #1;
            chk("ack_drop_on_reset", 64'(wbs_ack_o), 64'd0);
        end
        tick(1);
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
        la_data_in[64] = 1'b0;
    endtask

    task automatic rd(input int w, input logic [31:0] exp, input string name);
        wb_xfer(1'b0, w, 32'd0, 4'b0000, exp, name, 0);
    endtask

    task automatic wr(input int w, input logic [31:0] dat, input logic [3:0] sel);
        wb_xfer(1'b1, w, dat, sel, 32'd0, "wr", 0);
    endtask

    // Monitor: compare read data on ack, and ack never lasts two cycles
    always @(negedge wb_clk_i) begin
        if (wbs_ack_o) begin
            chk("ack_single_cycle", 64'(ack_prev), 64'd0);
            if (!wbs_we_i) begin
                chk("read_expected", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    mon_name = name_q.pop_front();
                    mon_exp  = exp_q.pop_front();
                    chk(mon_name, 64'(wbs_dat_o), 64'(mon_exp));
                end
            end
        end
        ack_prev <= wbs_ack_o;
    end

    initial begin
        wb_rst_i = 1'b1;
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
        wbs_sel_i = 4'h0; wbs_adr_i = 32'd0; wbs_dat_i = 32'd0;
        la_data_in = {128{1'b0}}; la_oenb = {128{1'b1}}; io_in = 38'd0;
        tick(3);
        wb_rst_i = 1'b0;
        tick(1);

        // Reset state
        exp_oeb = {38{1'b1}};
        exp_oeb[IO_LSB +: NUM_CH] = {NUM_CH{1'b0}};
        chk("rst_ack", 64'(wbs_ack_o), 64'd0);
        chk("rst_dat", 64'(wbs_dat_o), 64'd0);
        chk("rst_irq", 64'(irq), 64'd0);
        chk("rst_la", 64'(la_data_out[63:0]), 64'd0);
        chk("rst_io_out", 64'(io_out), 64'd0);
        chk("rst_io_oeb", 64'(io_oeb), 64'(exp_oeb));
        rd(0, 32'd0, "rst_ctrl0");
        rd(1, 32'd0, "rst_value0");
        rd(2, 32'd0, "rst_compare0");
        rd(3, 32'd0, "rst_status0");
        rd(32, 32'd0, "rst_irqsum");

        // Unmapped word and absent channel ignore writes, read 0
        wr(20, 32'hFFFF_FFFF, 4'hF);
        rd(20, 32'd0, "absent_ch_read");
        wr(40, 32'hFFFF_FFFF, 4'hF);
        rd(40, 32'd0, "unmapped_read");

        // Take LA control of clear/freeze; freeze counting
        la_oenb[64] = 1'b0; la_oenb[65] = 1'b0;
        la_data_in[64] = 1'b0; la_data_in[65] = 1'b0;

        // Channel 1: up count with reload at COMPARE=5
        wr(6, 32'd5, 4'hF);
        wr(4, 32'hFFFF_FF0B, 4'hF);
        rd(4, 32'h0000_000B, "ch1_ctrl");
        rd(6, 32'd5, "ch1_compare");
        rd(5, 32'd0, "ch1_value_frozen");
        la_data_in[65] = 1'b1;
        tick(5);
        chk("ch1_io_before_match", 64'(io_out[IO_LSB+1]), 64'd0);
        tick(1);
        chk("ch1_io_match", 64'(io_out[IO_LSB+1]), 64'd1);
        chk("ch1_la_match", 64'(la_data_out[33]), 64'd1);
        chk("ch1_irq_lag", 64'(irq), 64'd0);
        tick(1);
        chk("ch1_irq", 64'(irq), 64'd1);
        la_data_in[65] = 1'b0;
        rd(5, 32'd1, "ch1_value_after_reload");
        rd(7, 32'd1, "ch1_status");
        rd(32, 32'd2, "irqsum_ch1");
        wr(7, 32'd1, 4'b0001);
        tick(1);
        chk("ch1_irq_cleared", 64'(irq), 64'd0);
        chk("ch1_io_cleared", 64'(io_out[IO_LSB+1]), 64'd0);

        // Channel 0: down count without reload wraps to all-ones
        wr(1, 32'd2, 4'hF);
        wr(0, 32'd5, 4'hF);
        chk("ch0_la_start", 64'(la_data_out[31:0]), 64'd2);
        la_data_in[65] = 1'b1;
        tick(1);
        chk("ch0_down_1", 64'(la_data_out[31:0]), 64'd1);
        tick(1);
        chk("ch0_down_0", 64'(la_data_out[31:0]), 64'd0);
        chk("ch0_no_match_yet", 64'(la_data_out[32]), 64'd0);
        tick(1);
        chk("ch0_wrap", 64'(la_data_out[31:0]), 64'h0000_0000_FFFF_FFFF);
        chk("ch0_la_match", 64'(la_data_out[32]), 64'd1);
        chk("ch0_io_match", 64'(io_out[IO_LSB]), 64'd1);
        la_data_in[65] = 1'b0;
        tick(1);
        chk("ch0_frozen", 64'(la_data_out[31:0]), 64'h0000_0000_FFFF_FFFF);
        chk("ch0_no_irq", 64'(irq), 64'd0);

        // Byte-enabled write, then a write racing a count step
        wr(1, 32'hAAAA_AAAA, 4'hF);
        wr(1, 32'h0000_1234, 4'b0001);
        rd(1, 32'hAAAA_AA34, "byte_write");
        la_data_in[65] = 1'b1;
        wr(1, 32'h0000_0100, 4'hF);
        chk("write_beats_count", 64'(la_data_out[31:0]), 64'h100);
        tick(1);
        chk("count_after_write", 64'(la_data_out[31:0]), 64'hFF);
        la_data_in[65] = 1'b0;

        // Channel 2: match every cycle; W1C racing a new match keeps MATCH
        wr(8, 32'd3, 4'hF);
        la_data_in[65] = 1'b1;
        wr(11, 32'd1, 4'b0001);
        la_data_in[65] = 1'b0;
        rd(11, 32'd1, "w1c_race_keeps_match");
        wr(11, 32'd1, 4'b0001);
        rd(11, 32'd0, "w1c_clears");

        // LA clear wins over a concurrent VALUE write; other registers kept
        wb_xfer(1'b1, 1, 32'h0000_0055, 4'hF, 32'd0, "wr_clear", 1);
        chk("la_clear_beats_write", 64'(la_data_out[31:0]), 64'd0);
        rd(0, 32'd5, "ctrl_kept_after_clear");
        rd(6, 32'd5, "compare_kept_after_clear");

        // Reset during a write's ack cycle drops ack and loses the write
        wb_xfer(1'b1, 14, 32'h0000_0077, 4'hF, 32'd0, "wr_reset", 2);
        tick(1);
        wb_rst_i = 1'b0;
        tick(1);
        rd(14, 32'd0, "write_lost_on_reset");
        rd(0, 32'd0, "ctrl0_after_reset");
        chk("irq_after_reset", 64'(irq), 64'd0);

        // Access outside the window is never acknowledged
        miss_acks = 0;
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0;
        wbs_adr_i = BASE + 32'h0000_0100;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            if (wbs_ack_o) miss_acks++;
        end
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
        chk("miss_no_ack", 64'(miss_acks), 64'd0);
        tick(2);
        chk("all_reads_acked", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
